// File: rtl/phys_free_list.sv
// Rename-stage free list of physical register indices: a circular buffer walked by
// alloc head, commit head and free tail, with flush recovery back to the commit head.
module phys_free_list #(
    parameter int s_index = 6,
    parameter int num_arch = 32,
    localparam int num_regs = 2 ** s_index,
    localparam int depth = num_regs - num_arch,
    localparam int iw = $clog2(depth),
    localparam int pw = iw + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_req,
    output logic               alloc_valid,
    output logic [s_index-1:0] alloc_preg,
    input  logic               commit_valid,
    input  logic [s_index-1:0] commit_old_preg,
    input  logic               flush,
    output logic [pw-1:0]      free_count
);

    // Handshake: a register is consumed only in a cycle where alloc_req and
    // alloc_valid are both high and flush is low; alloc_valid never depends on
    // alloc_req, so rename may look at it before deciding to request.

    logic [s_index-1:0] entries [depth];
    logic [pw-1:0]      ahead;
    logic [pw-1:0]      chead;
    logic [pw-1:0]      tail;

    logic               do_alloc;
    logic               do_free;
    logic [pw-1:0]      chead_next;

    always_comb begin
        free_count  = tail - ahead;
        alloc_valid = (free_count != '0);
        alloc_preg  = entries[ahead[iw-1:0]];
        do_alloc    = alloc_req && alloc_valid && !flush;
        // Physical 0 is the hardwired zero register and never re-enters the list.
        do_free     = commit_valid && (commit_old_preg != '0);
        chead_next  = chead + pw'(commit_valid);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                entries[i] <= s_index'(num_arch + i);
            end
            ahead <= '0;
            chead <= '0;
            tail  <= pw'(depth);
        end else begin
            if (do_free) begin
                entries[tail[iw-1:0]] <= commit_old_preg;
                tail                  <= tail + pw'(1);
            end
            chead <= chead_next;
            // Flush rewinds speculative allocations, keeping this cycle's commit.
            if (flush) begin
                ahead <= chead_next;
            end else if (do_alloc) begin
                ahead <= ahead + pw'(1);
            end
        end
    end

endmodule
